// File: rtl/clk_sched_pkg.sv
// Shared types and default constants for the clock-enable scheduler.
// The FSM encoding is fixed at 2 bits so it matches any debug taps.
package clk_sched_pkg;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_STEP = 2'd2,
        ST_ACK  = 2'd3
    } sched_state_t;

    localparam int PIX_DIV_DEF   = 4;
    localparam int IO_DIV_DEF    = 100000;
    localparam int CPU_DIV_W_DEF = 8;

endpackage

// File: rtl/en_pulse_div.sv
// Free-running wrap counter 0..DIV-1 with a registered one-cycle pulse.
// The pulse is high in the cycle the count equals DIV-1. DIV must be >= 2.
module en_pulse_div #(
    parameter int DIV = 4
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic pulse
);

    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             pulse_reg;

    always_comb begin
        cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
    end

    // The pulse register is loaded from the next count, so it lines up with cnt_reg.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg   <= '0;
            pulse_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            pulse_reg <= (cnt_next == CNT_LAST);
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/clk_en_scheduler.sv
// Clock-enable scheduler: fixed pixel enable, slow IO tick and a programmable
// CPU enable with run / halt / single-step control. All outputs are registered.
module clk_en_scheduler
    import clk_sched_pkg::*;
#(
    parameter int PIX_DIV     = PIX_DIV_DEF,
    parameter int IO_DIV      = IO_DIV_DEF,
    parameter int CPU_DIV_W   = CPU_DIV_W_DEF,
    parameter int CPU_DIV_RST = 0
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 cfg_wr,
    input  logic [CPU_DIV_W-1:0] cfg_cpu_div,
    input  logic                 halt_req,
    input  logic                 step_req,
    output logic                 cpu_en,
    output logic                 pix_en,
    output logic                 io_tick,
    output logic                 cpu_halted,
    output logic                 step_ack
);

    localparam logic [CPU_DIV_W-1:0] DIV_RST = CPU_DIV_W'(CPU_DIV_RST);

    sched_state_t         state_reg, state_next;
    logic [CPU_DIV_W-1:0] cnt_reg, cnt_next;
    logic [CPU_DIV_W-1:0] div_reg, div_next;
    logic [CPU_DIV_W-1:0] shadow_reg, shadow_next;
    logic                 live_reg;
    logic                 boundary;
    logic                 cpu_en_reg;
    logic                 halted_reg;
    logic                 step_ack_reg;

    en_pulse_div #(.DIV(PIX_DIV)) u_pix_div (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .pulse  (pix_en)
    );

    en_pulse_div #(.DIV(IO_DIV)) u_io_div (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .pulse  (io_tick)
    );

    // The first cycle after reset release shows reset outputs, so it is never a boundary.
    always_comb begin
        shadow_next = cfg_wr ? cfg_cpu_div : shadow_reg;
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        div_next    = div_reg;
        boundary    = live_reg && (cnt_reg == div_reg) &&
                      ((state_reg == ST_RUN) || (state_reg == ST_STEP));
        if (live_reg) begin
            case (state_reg)
                ST_RUN: begin
                    if (boundary) begin
                        cnt_next = '0;
                        div_next = shadow_next;
                        if (halt_req) begin
                            state_next = ST_HALT;
                        end
                    end else begin
                        cnt_next = cnt_reg + CPU_DIV_W'(1);
                    end
                end
                ST_HALT: begin
                    cnt_next = '0;
                    div_next = shadow_next;
                    if (!halt_req) begin
                        state_next = ST_RUN;
                    end else if (step_req) begin
                        state_next = ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (boundary) begin
                        cnt_next   = '0;
                        div_next   = shadow_next;
                        state_next = ST_ACK;
                    end else begin
                        cnt_next = cnt_reg + CPU_DIV_W'(1);
                    end
                end
                default: begin
                    cnt_next   = '0;
                    state_next = halt_req ? ST_HALT : ST_RUN;
                end
            endcase
        end
    end

    // Output flops decode the next state so they coincide with the cycle they describe.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_RUN;
            cnt_reg      <= '0;
            div_reg      <= DIV_RST;
            shadow_reg   <= DIV_RST;
            live_reg     <= 1'b0;
            cpu_en_reg   <= 1'b0;
            halted_reg   <= 1'b0;
            step_ack_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            div_reg      <= div_next;
            shadow_reg   <= shadow_next;
            live_reg     <= 1'b1;
            cpu_en_reg   <= ((state_next == ST_RUN) || (state_next == ST_STEP)) &&
                            (cnt_next == div_next);
            halted_reg   <= (state_next == ST_HALT);
            step_ack_reg <= (state_next == ST_ACK);
        end
    end

    assign cpu_en     = cpu_en_reg;
    assign cpu_halted = halted_reg;
    assign step_ack   = step_ack_reg;

endmodule
